// File: rtl/sdram_responder_if.sv
// Cache-side SDRAM request/response bus: request/ready handshake plus read-beat return path.
// The master drives requests and the slave (the memory) returns beats.
interface sdram_responder_if;
  logic        sdram_ready;
  logic        sdram_request;
  logic [25:0] sdram_addr;
  logic        sdram_write;
  logic        sdram_burst;
  logic [3:0]  sdram_wstrb;
  logic [31:0] sdram_wdata;
  logic        sdram_rvalid;
  logic [31:0] sdram_rdata;
  logic [25:0] sdram_raddress;
  logic        sdram_complete;

  modport master (
    input  sdram_ready,
    output sdram_request,
    output sdram_addr,
    output sdram_write,
    output sdram_burst,
    output sdram_wstrb,
    output sdram_wdata,
    input  sdram_rvalid,
    input  sdram_rdata,
    input  sdram_raddress,
    input  sdram_complete
  );

  modport slave (
    output sdram_ready,
    input  sdram_request,
    input  sdram_addr,
    input  sdram_write,
    input  sdram_burst,
    input  sdram_wstrb,
    input  sdram_wdata,
    output sdram_rvalid,
    output sdram_rdata,
    output sdram_raddress,
    output sdram_complete
  );
endinterface

// File: rtl/sdram_responder.sv
// On-chip memory answering the cache-side SDRAM protocol: byte-strobed single writes and
// single or 16-beat critical-word-first wrapping burst reads after a fixed latency.
module sdram_responder #(
  parameter int unsigned MEM_WORDS_LOG2 = 14,
  parameter int unsigned READ_LATENCY   = 3
) (
  input logic              clock,
  input logic              reset,
  sdram_responder_if.slave bus
);

  localparam int unsigned Depth = 2 ** MEM_WORDS_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StBeat} state_e;

  state_e                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      complete_q, complete_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [25:0]               raddress_q, raddress_d;
  logic [19:0]               line_q, line_d;
  logic [3:0]                word_q, word_d;
  logic [4:0]                beats_q, beats_d;
  logic [3:0]                wait_q, wait_d;

  logic [31:0]               mem_q [Depth];
  logic                      accept, accept_rd, accept_wr;
  logic [MEM_WORDS_LOG2-1:0] rd_idx, wr_idx;

  assign accept    = bus.sdram_request & ready_q;
  assign accept_rd = accept & ~bus.sdram_write;
  assign accept_wr = accept & bus.sdram_write;

  // Higher address bits are dropped so addresses alias modulo the memory size.
  assign rd_idx = MEM_WORDS_LOG2'({line_q, word_q});
  assign wr_idx = MEM_WORDS_LOG2'(bus.sdram_addr[25:2]);

  // Memory contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (accept_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sdram_wstrb[i]) begin
          mem_q[wr_idx][8*i +: 8] <= bus.sdram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    rvalid_d   = 1'b0;
    complete_d = 1'b0;
    rdata_d    = rdata_q;
    raddress_d = raddress_q;
    line_d     = line_q;
    word_d     = word_q;
    beats_d    = beats_q;
    wait_d     = wait_q;

    unique case (state_q)
      StIdle: begin
        // Ready only rises one cycle after re-entering idle, keeping it low on the final beat.
        ready_d = 1'b1;
        if (accept_rd) begin
          ready_d = 1'b0;
          line_d  = bus.sdram_addr[25:6];
          word_d  = bus.sdram_addr[5:2];
          beats_d = bus.sdram_burst ? 5'd16 : 5'd1;
          wait_d  = 4'(READ_LATENCY - 1);
          state_d = (READ_LATENCY > 1) ? StWait : StBeat;
        end
      end
      StWait: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = StBeat;
        end
      end
      StBeat: begin
        // The read is issued here; data, address and valid register together at the edge.
        rvalid_d   = 1'b1;
        rdata_d    = mem_q[rd_idx];
        raddress_d = {line_q, word_q, 2'b00};
        complete_d = (beats_q == 5'd1);
        word_d     = word_q + 4'd1;
        beats_d    = beats_q - 5'd1;
        if (beats_q == 5'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      complete_q <= 1'b0;
      rdata_q    <= '0;
      raddress_q <= '0;
      line_q     <= '0;
      word_q     <= '0;
      beats_q    <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      complete_q <= complete_d;
      rdata_q    <= rdata_d;
      raddress_q <= raddress_d;
      line_q     <= line_d;
      word_q     <= word_d;
      beats_q    <= beats_d;
      wait_q     <= wait_d;
    end
  end

  assign bus.sdram_ready    = ready_q;
  assign bus.sdram_rvalid   = rvalid_q;
  assign bus.sdram_complete = complete_q;
  assign bus.sdram_rdata    = rdata_q;
  assign bus.sdram_raddress = raddress_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed plus randomized bench for sdram_responder against a word-array reference model
// that applies the byte-strobe, aliasing and wrap-order rules directly.
module tb_sdram_responder;

  localparam int unsigned Log2 = 14;
  localparam int unsigned Lat  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sdram_responder_if bus ();

  sdram_responder #(
    .MEM_WORDS_LOG2(Log2),
    .READ_LATENCY  (Lat)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] ref_mem [2 ** Log2];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int unsigned widx(input logic [25:0] a);
    return int'(a >> 2) % (2 ** Log2);
  endfunction

  task automatic do_write(input logic [25:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int waited);
    int unsigned ix;
    bus.sdram_request = 1'b1;
    bus.sdram_write   = 1'b1;
    bus.sdram_burst   = 1'($urandom);
    bus.sdram_addr    = a;
    bus.sdram_wstrb   = s;
    bus.sdram_wdata   = d;
    waited = 0;
    while (!bus.sdram_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("wr_timeout", 64'(waited), 64'(0));
    ix = widx(a);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) ref_mem[ix][8*i +: 8] = d[8*i +: 8];
    end
    tick();
    bus.sdram_request = 1'b0;
  endtask

  task automatic do_read(input logic [25:0] a, input logic burst, input logic hold,
                         input logic [25:0] hold_a, input string tag, output int waited);
    int nb;
    int lat;
    logic [25:0] exp_addr;
    bus.sdram_request = 1'b1;
    bus.sdram_write   = 1'b0;
    bus.sdram_burst   = burst;
    bus.sdram_addr    = a;
    bus.sdram_wstrb   = 4'($urandom);
    bus.sdram_wdata   = $urandom;
    waited = 0;
    while (!bus.sdram_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check({tag, "_accept_timeout"}, 64'(waited), 64'(0));
    nb = burst ? 16 : 1;
    tick();
    if (hold) begin
      bus.sdram_burst = 1'b0;
      bus.sdram_addr  = hold_a;
    end else begin
      bus.sdram_request = 1'b0;
    end
    check({tag, "_ready_drop"}, 64'(bus.sdram_ready), 64'(0));
    lat = 0;
    while (!bus.sdram_rvalid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(Lat));
    for (int b = 0; b < nb; b++) begin
      if (b > 0) tick();
      exp_addr = (a & ~26'h3f) + 26'((((a >> 2) + b) % 16) * 4);
      check($sformatf("%s_b%0d_rvalid", tag, b), 64'(bus.sdram_rvalid), 64'(1));
      check($sformatf("%s_b%0d_raddr", tag, b), 64'(bus.sdram_raddress), 64'(exp_addr));
      check($sformatf("%s_b%0d_rdata", tag, b), 64'(bus.sdram_rdata),
            64'(ref_mem[widx(exp_addr)]));
      check($sformatf("%s_b%0d_complete", tag, b), 64'(bus.sdram_complete),
            64'(b == nb - 1));
      check($sformatf("%s_b%0d_ready", tag, b), 64'(bus.sdram_ready), 64'(0));
    end
    tick();
    check({tag, "_post_rvalid"}, 64'(bus.sdram_rvalid), 64'(0));
    check({tag, "_post_complete"}, 64'(bus.sdram_complete), 64'(0));
    check({tag, "_post_ready"}, 64'(bus.sdram_ready), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int bad;
    int cnt;
    logic [25:0] a;

    bus.sdram_request = 1'b0;
    bus.sdram_write   = 1'b0;
    bus.sdram_burst   = 1'b0;
    bus.sdram_addr    = '0;
    bus.sdram_wstrb   = '0;
    bus.sdram_wdata   = '0;

    // Reset held for five cycles.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.sdram_ready !== 1'b0 || bus.sdram_rvalid !== 1'b0) bad++;
    end
    check("reset_ready_rvalid_low", 64'(bad), 64'(0));
    check("reset_rdata", 64'(bus.sdram_rdata), 64'(0));
    check("reset_raddress", 64'(bus.sdram_raddress), 64'(0));
    check("reset_complete", 64'(bus.sdram_complete), 64'(0));
    reset = 1'b1;
    tick();
    check("ready_after_reset", 64'(bus.sdram_ready), 64'(1));

    // Byte-strobed write then read-after-write.
    do_write(26'h000100, 4'b1111, 32'hDEADBEEF, w);
    do_write(26'h000100, 4'b0010, 32'h0000AA00, w);
    check("strobe_model", 64'(ref_mem[widx(26'h000100)]), 64'(32'hDEADAAEF));
    do_read(26'h000100, 1'b0, 1'b0, 26'h0, "raw", w);

    // Wrapping burst starting at word 14.
    for (int i = 0; i < 16; i++) do_write(26'h001200 + 26'(i * 4), 4'hf, $urandom, w);
    do_read(26'h001238, 1'b1, 1'b0, 26'h0, "wrap", w);

    // Back-to-back writes, then a burst over them.
    for (int i = 4; i < 16; i++) do_write(26'h000040 + 26'(i * 4), 4'hf, $urandom, w);
    for (int i = 0; i < 4; i++) begin
      do_write(26'h000040 + 26'(i * 4), 4'hf, 32'(i + 1), w);
      check($sformatf("b2b_wr%0d_wait", i), 64'(w), 64'(0));
    end
    do_read(26'h000040, 1'b1, 1'b0, 26'h0, "b2b", w);

    // Held single read during a burst.
    do_write(26'h002000, 4'hf, 32'h12345678, w);
    do_read(26'h001208, 1'b1, 1'b1, 26'h002000, "holdburst", w);
    do_read(26'h002000, 1'b0, 1'b0, 26'h0, "held", w);
    check("held_accept_wait", 64'(w), 64'(0));

    // Aliasing, plus a no-op zero-strobe write.
    do_write(26'h010004, 4'hf, 32'hCAFEF00D, w);
    do_write(26'h000004, 4'h0, 32'hFFFFFFFF, w);
    do_read(26'h000004, 1'b0, 1'b0, 26'h0, "alias", w);
    check("alias_model", 64'(ref_mem[widx(26'h000004)]), 64'(32'hCAFEF00D));

    // Reset during beat 5 of a burst.
    bus.sdram_request = 1'b1;
    bus.sdram_write   = 1'b0;
    bus.sdram_burst   = 1'b1;
    bus.sdram_addr    = 26'h001200;
    cnt = 0;
    while (!bus.sdram_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    bus.sdram_request = 1'b0;
    cnt = 0;
    while (!bus.sdram_rvalid && cnt < 40) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 5; i++) tick();
    check("mid_beat5_raddr", 64'(bus.sdram_raddress), 64'(26'h001214));
    reset = 1'b0;
    #1;
    check("mid_reset_rvalid", 64'(bus.sdram_rvalid), 64'(0));
    check("mid_reset_ready", 64'(bus.sdram_ready), 64'(0));
    check("mid_reset_complete", 64'(bus.sdram_complete), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.sdram_rvalid) cnt++;
    end
    check("no_beats_after_reset", 64'(cnt), 64'(0));
    check("ready_after_mid_reset", 64'(bus.sdram_ready), 64'(1));
    do_read(26'h000100, 1'b0, 1'b0, 26'h0, "persist", w);

    // Randomized traffic over four initialized lines with aliased upper address bits.
    for (int i = 0; i < 64; i++) do_write(26'h003000 + 26'(i * 4), 4'hf, $urandom, w);
    for (int n = 0; n < 40; n++) begin
      a = {10'($urandom), 16'h3000 + 16'($urandom_range(0, 63) * 4)};
      case ($urandom_range(0, 2))
        0: do_write(a, 4'($urandom), $urandom, w);
        1: do_read(a, 1'b0, 1'b0, 26'h0, $sformatf("rnd%0d_s", n), w);
        default: do_read(a, 1'b1, 1'b0, 26'h0, $sformatf("rnd%0d_b", n), w);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- On-chip memory that answers the cache-side SDRAM request protocol: request/ready handshake, single or 16-beat burst reads, and single byte-strobed writes.
- Sits where the SDRAM controller normally sits, behind data_cache or an instruction cache.
- Serves as fast block-RAM memory and as a protocol-exact stand-in for the SDRAM controller in system benches.
- Bursts wrap within the 64-byte line, starting at the requested word (critical word first).

Parameters:
MEM_WORDS_LOG2  14  log2 of memory depth in 32-bit words (default 64KB)
READ_LATENCY  3  cycles from the read-acceptance edge to the first rvalid; legal range 1..15

Ports:
clock  input  1  single clock, all logic on its rising edge
reset  input  1  asynchronous, active-low (0 = in reset)
sdram_ready  output  1  responder accepts a request this cycle
sdram_request  input  1  requester presents a request
sdram_addr  input  26  byte address; bits [1:0] ignored
sdram_write  input  1  0=read, 1=write
sdram_burst  input  1  1=16-beat read burst, 0=single
sdram_wstrb  input  4  byte enables for a write
sdram_wdata  input  32  write data; ignored on reads
sdram_rvalid  output  1  read beat valid
sdram_rdata  output  32  read beat data
sdram_raddress  output  26  byte address of the current beat, bits [1:0]=0
sdram_complete  output  1  final beat of the transaction; qualified by rvalid

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Outputs in reset: ready=0, rvalid=0, complete=0, rdata=0, raddress=0, state=IDLE, counters=0.
- Memory contents are not cleared by reset.
- Ready after reset: ready is a registered output. It goes to 1 on the first rising edge after reset deasserts.
- Transfer rule:
  - A transfer occurs on a rising edge where request=1 and ready=1.
  - Request-side signals are sampled only at that edge and are don't-care otherwise.
  - At most one transfer per cycle.
- Addressing: word index = addr[MEM_WORDS_LOG2+1:2]. Higher bits are ignored, so addresses alias modulo the memory size.
- Writes:
  - The memory is updated at the acceptance edge, per byte lane where wstrb[i]=1. wstrb=0000 is a no-op.
  - burst is ignored on writes; every write is single-beat.
  - No rvalid is produced for a write.
  - ready stays 1, so back-to-back writes are accepted every cycle.
- Reads (states IDLE, WAIT, BEAT):
  - IDLE: ready=1. An accepted read moves to WAIT, latches base line = addr[25:6], latches start word = addr[5:2], loads beats = burst ? 16 : 1, and drives ready=0 from the next cycle.
  - WAIT: counts READ_LATENCY-1 cycles, then moves to BEAT. With READ_LATENCY=1, the first rvalid is the cycle right after acceptance.
  - BEAT: rvalid=1 every cycle, with no gaps. Beat k (k=0..beats-1) reports raddress = {base line, (start+k) mod 16, 2'b00} and rdata = memory at that word.
  - complete=1 only on the last beat: beat 0 for a single read, beat 15 for a burst.
  - After the last beat: return to IDLE, and ready=1 on the following cycle.
- Latency: first rvalid is exactly READ_LATENCY cycles after the acceptance edge.
- Read-after-write: a write accepted at edge N followed by a read accepted at N+1 to the same word returns the written data. The memory read is issued no earlier than the WAIT/BEAT cycles.
- Request during a read: ready=0 for the whole of WAIT and BEAT. A held request is accepted in the first IDLE cycle after complete.
- Reset mid-operation: rvalid, complete and ready drop to 0 asynchronously. No remaining beats are issued after release. Writes already accepted persist.
- Outputs when rvalid=0: rdata and raddress hold their last values; complete=0.

Test Plan:
- Reset: hold reset=0 for 5 cycles → ready=0 and rvalid=0 throughout; release → ready=1 at the next edge.
- Byte-strobed write then read:
  - Stimulus: write 0x000100 wstrb=1111 data=0xDEADBEEF; next cycle write 0x000100 wstrb=0010 data=0x0000AA00; then single read 0x000100 with READ_LATENCY=3.
  - Response: exactly one beat, 3 cycles after acceptance, rdata=0xDEADAAEF, raddress=0x000100, complete=1.
- Wrapping burst:
  - Stimulus: burst read at 0x001238 (word 14).
  - Response: 16 consecutive beats with raddress 0x001238, 0x00123C, 0x001200, ..., 0x001234; complete only on the beat with raddress 0x001234; ready=0 from the cycle after acceptance through that beat; ready=1 the cycle after.
- Back-to-back writes:
  - Stimulus: four writes to 0x40, 0x44, 0x48, 0x4C in four consecutive cycles with data 1..4; then a burst read at 0x40.
  - Response: all four writes accepted with ready held at 1; burst beats 0..3 return 1, 2, 3, 4.
- Held read:
  - Stimulus: during a burst, present a single read of 0x2000 and hold it.
  - Response: not accepted until the cycle after complete; its rvalid follows READ_LATENCY later.
- Aliasing and reset mid-burst:
  - Stimulus: with MEM_WORDS_LOG2=14, write 0x010004, then read 0x000004; separately, assert reset during beat 5 of a burst.
  - Response: the read of 0x000004 returns the data written to 0x010004; on the mid-burst reset, rvalid=0 immediately and no further beats occur after release.
